// File: rtl/round_fifo.sv
// Circular-buffer FIFO with wrap-flag full/empty detection and a registered valid/ready read port.
// Capacity is BufferSize storage entries plus the output register; pushes while Full are dropped and flagged.
module round_fifo #(
  parameter int DataWidth   = 8,
  parameter int BufferWidth = 4,
  parameter int BufferSize  = 16
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   Push,
  input  logic [DataWidth-1:0]   W_Data,
  output logic                   Full,
  output logic                   Empty,
  output logic                   Overflow,
  output logic                   R_Valid,
  input  logic                   R_Ready,
  output logic [DataWidth-1:0]   R_Data,
  output logic [BufferWidth:0]   Count
);

  localparam logic [BufferWidth-1:0] LastAddr = BufferWidth'(BufferSize - 1);

  logic [DataWidth-1:0]   mem [BufferSize];
  logic [BufferWidth-1:0] w_addr;
  logic [BufferWidth-1:0] r_addr;
  logic                   round;

  logic push_ok;
  logic pop;
  logic handshake;
  logic w_wrap;
  logic r_wrap;
  logic ptr_eq;

  assign ptr_eq    = (w_addr == r_addr);
  assign Empty     = ptr_eq && !round;
  assign Full      = ptr_eq && round;
  assign push_ok   = Push && !Full;
  assign pop       = !Empty && (!R_Valid || R_Ready);
  assign handshake = R_Valid && R_Ready;
  assign w_wrap    = push_ok && (w_addr == LastAddr);
  assign r_wrap    = pop && (r_addr == LastAddr);

  // Storage is deliberately left out of reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[w_addr] <= W_Data;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      w_addr   <= '0;
      r_addr   <= '0;
      round    <= 1'b0;
      R_Valid  <= 1'b0;
      R_Data   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      Overflow <= Push && Full;

      if (push_ok) begin
        w_addr <= w_wrap ? '0 : w_addr + BufferWidth'(1);
      end

      if (pop) begin
        R_Data  <= mem[r_addr];
        R_Valid <= 1'b1;
        r_addr  <= r_wrap ? '0 : r_addr + BufferWidth'(1);
      end else if (handshake) begin
        R_Valid <= 1'b0;
      end

      // Simultaneous wraps cancel so the pointer distance stays consistent.
      if (w_wrap && !r_wrap) begin
        round <= 1'b1;
      end else if (r_wrap && !w_wrap) begin
        round <= 1'b0;
      end

      case ({push_ok, handshake})
        2'b10:   Count <= Count + (BufferWidth + 1)'(1);
        2'b01:   Count <= Count - (BufferWidth + 1)'(1);
        default: Count <= Count;
      endcase
    end
  end

endmodule

// File: doc/round_fifo.md
# round_fifo

Circular-buffer FIFO with a registered, valid/ready read port. It is the consumer-facing counterpart of the write-side wrap tracking: it owns the storage, both address pointers and the Round wrap flag, and delivers words in order to a downstream stage that may stall. It sits between a producer that issues `Push` strobes and convolution datapath stages that take data under a ready handshake.

## Interface

Parameters:

- `DataWidth`, 8: word width.
- `BufferWidth`, 4: address width.
- `BufferSize`, 16: storage depth. Legal range is 2 ≤ `BufferSize` ≤ 2**`BufferWidth`; non-power-of-two values are allowed.

Ports (one clock; reset is asynchronous and active-low):

- `clk` in 1: rising-edge clock.
- `aclr` in 1: asynchronous active-low reset. 0 resets, 1 runs.
- `Push` in 1: write strobe. `W_Data` is accepted on this edge when `Full`=0.
- `W_Data` in `DataWidth`: write data.
- `Full` out 1: storage full. A push in this cycle is rejected.
- `Empty` out 1: storage empty. The output register is excluded.
- `Overflow` out 1: one-cycle pulse, asserted the cycle after a rejected push.
- `R_Valid` out 1: `R_Data` holds a word.
- `R_Ready` in 1: downstream accepts `R_Data` when `R_Valid`=1.
- `R_Data` out `DataWidth`: output word, registered.
- `Count` out `BufferWidth`+1: words held, equal to storage entries plus `R_Valid`. Range 0..`BufferSize`+1.

## Operation

- Internal state: `W_Addr`, `R_Addr` (`BufferWidth` bits each), `Round` (1 bit), a storage array of `BufferSize` × `DataWidth`, and the output register.
- Write: if `Push` && !`Full`, store `W_Data` at `W_Addr`. Then `W_Addr` increments. From `BufferSize`-1 it wraps to 0.
- Internal pop: `pop = !Empty && (!R_Valid || R_Ready)`. On `pop`:
  - `R_Data` ← `mem[R_Addr]`.
  - `R_Valid` ← 1.
  - `R_Addr` increments, wrapping from `BufferSize`-1 to 0.
- If `R_Valid` && `R_Ready` && `Empty`, then `R_Valid` ← 0 and `R_Data` holds its last value.
- If `R_Valid` && !`R_Ready`, then `R_Valid` and `R_Data` hold unchanged.
- Round flag:
  - Set on a write that wraps `W_Addr`.
  - Cleared on a pop that wraps `R_Addr`.
  - If both happen in the same cycle, it holds. This case is unreachable, but the rule is mandatory.
- Status, combinational from registered state:
  - `Empty` = (`W_Addr`==`R_Addr`) && !`Round`.
  - `Full` = (`W_Addr`==`R_Addr`) && `Round`.
- `Full` is evaluated before the edge. A push while `Full`=1 is rejected even if a pop occurs in the same cycle.
- Rejected push:
  - Storage and pointers are unchanged.
  - `Overflow`=1 for exactly the next cycle.
  - Consecutive rejected pushes hold `Overflow` high, one pulse per rejected cycle.
- Storage read on an internal pop and storage write on an accepted push may happen in the same cycle. They target different entries whenever both are legal.
- `Count` is a register, updated by +1 on an accepted push and −1 on an `R_Valid` && `R_Ready` handshake. If both occur in the same cycle it is unchanged.
- Total capacity is `BufferSize`+1 words: the storage plus the output register.

## Timing

- Reset (`aclr`=0, asynchronous) sets:
  - `W_Addr`=0, `R_Addr`=0, `Round`=0.
  - `R_Valid`=0, `R_Data`=0, `Count`=0, `Overflow`=0.
  - Derived outputs: `Empty`=1, `Full`=0.
  - Storage contents are not reset.
- Reset mid-operation discards all held words. The first valid data after release is the first accepted push after release.
- Latency: a push accepted at edge N into an empty FIFO gives `R_Valid`=1 with that word after edge N+1. That is 2 cycles from `Push` assertion.
- Throughput: with `R_Ready` held at 1 and `Push` every cycle, one word per cycle sustained with no bubbles.
- `R_Data` is stable throughout any stall: `R_Valid`=1 and `R_Ready`=0.
- `Full`, `Empty` and `Count` change only on rising `clk` edges or on reset.

## Test plan

- Reset: drive `aclr`=0 with random inputs. Required: `R_Valid`=0, `Count`=0, `Empty`=1, `Full`=0, `Overflow`=0. Then release and push 0x5A once. Required: `R_Valid`=1 with `R_Data`=0x5A two edges later.
- Fill and overflow (`BufferSize`=16): with `R_Ready`=0, push 0x00..0x10 (17 words). Required: `Full`=1 and `Count`=17 after the 17th. An 18th push (0xFF) gives a one-cycle `Overflow` pulse with `Count` still 17. Then set `R_Ready`=1. Required: 0x00..0x10 drain in order and 0xFF never appears.
- Wrap streaming: `R_Ready`=1, push 40 sequential words, one per cycle. Required: in-order output, one word per cycle after the first 2-cycle latency, `Round` toggling with no false `Full`/`Empty`, and `Count` ≤ 2 throughout.
- Backpressure: continuous pushes with `R_Ready` toggling 1,0,0,1 repeating. Required: `R_Data` constant across every stall, no lost or duplicated words, and `Count` matching the scoreboard every cycle.
- Non-power-of-two (`BufferWidth`=4, `BufferSize`=12): fill 13 words, drain 13, twice. Required: `R_Addr` and `W_Addr` never exceed 11, `Full` is asserted after 13 pushes, and the data order is correct.
- Reset mid-operation: with 9 words held, pulse `aclr` low between clock edges. Required: outputs reset immediately, with no clock needed, and none of the 9 words ever appear.
